// File: rtl/icache_assoc.sv
// Set-associative instruction cache with a miss/fill FSM, round-robin replacement,
// whole-cache invalidate and saturating hit/miss counters.
module icache_assoc #(
    parameter int WAYS     = 2,
    parameter int SETS     = 8,
    parameter int BLKWORDS = 2,
    parameter int COUNTW   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [31:0]       imemaddr,
    output logic              ihit,
    output logic [31:0]       imemload,
    input  logic              inv,
    output logic              iREN,
    output logic [31:0]       iaddr,
    input  logic              iwait,
    input  logic [31:0]       iload,
    output logic [COUNTW-1:0] hit_cnt,
    output logic [COUNTW-1:0] miss_cnt
);
    localparam int OFFW = $clog2(BLKWORDS);
    localparam int OFFS = (OFFW > 0) ? OFFW : 1;
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - OFFW - IDXW;
    localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [OFFS-1:0]   KLAST = OFFS'(BLKWORDS - 1);
    localparam logic [COUNTW-1:0] CMAX  = '1;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    state_t state, state_nx;

    logic            valid [WAYS][SETS];
    logic [TAGW-1:0] tags  [WAYS][SETS];
    logic [31:0]     data  [WAYS][SETS][BLKWORDS];
    logic [WAYW-1:0] rr    [SETS];

    logic [29:0]     wa;
    logic [OFFS-1:0] off;
    logic [IDXW-1:0] idx;
    logic [TAGW-1:0] tag;
    logic            unused_bytebits;

    logic [TAGW-1:0] ltag;
    logic [IDXW-1:0] lidx;
    logic [WAYW-1:0] lvic;
    logic            lvic_rr;
    logic [OFFS-1:0] k;

    logic            hit, miss, fill_we, install;
    logic [31:0]     hit_word;
    logic [WAYW-1:0] vic;
    logic            vic_rr;
    logic [29:0]     fill_wa;

    assign wa              = imemaddr[31:2];
    assign unused_bytebits = ^imemaddr[1:0];
    assign off             = OFFS'(wa) & KLAST;
    assign idx             = IDXW'(wa >> OFFW);
    assign tag             = TAGW'(wa >> (OFFW + IDXW));

    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w][idx] && tags[w][idx] == tag) begin
                hit      = 1'b1;
                hit_word = data[w][idx][off];
            end
        end
    end

    // Lowest-numbered invalid way wins; the round-robin pointer is the fallback.
    always_comb begin
        vic    = rr[idx];
        vic_rr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w][idx]) begin
                vic    = WAYW'(w);
                vic_rr = 1'b0;
            end
        end
    end

    assign fill_wa = (30'(ltag) << (OFFW + IDXW)) | (30'(lidx) << OFFW) | 30'(k & KLAST);
    assign iaddr   = iREN ? {fill_wa, 2'b00} : 32'h0;
    assign install = (state == DONE) && !inv;

    always_comb begin
        state_nx = state;
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        miss     = 1'b0;
        fill_we  = 1'b0;
        case (state)
            IDLE: begin
                if (imemREN) begin
                    if (hit) begin
                        ihit     = 1'b1;
                        imemload = hit_word;
                    end else if (!inv) begin
                        miss     = 1'b1;
                        state_nx = FILL;
                    end
                end
            end
            FILL: begin
                iREN = 1'b1;
                if (!iwait) begin
                    fill_we = 1'b1;
                    if (k == KLAST) state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Invalidate aborts any fill in progress.
        if (inv) begin
            state_nx = IDLE;
            fill_we  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            k        <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) valid[w][s] <= 1'b0;
        end else begin
            state <= state_nx;
            if (ihit && hit_cnt != CMAX)  hit_cnt  <= hit_cnt + COUNTW'(1);
            if (miss && miss_cnt != CMAX) miss_cnt <= miss_cnt + COUNTW'(1);
            if (miss)         k <= '0;
            else if (fill_we) k <= k + OFFS'(1);
            if (inv) begin
                for (int w = 0; w < WAYS; w++)
                    for (int s = 0; s < SETS; s++) valid[w][s] <= 1'b0;
            end else if (install) begin
                valid[lvic][lidx] <= 1'b1;
                if (lvic_rr) rr[lidx] <= (WAYS > 1) ? rr[lidx] + WAYW'(1) : '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (miss) begin
            ltag    <= tag;
            lidx    <= idx;
            lvic    <= vic;
            lvic_rr <= vic_rr;
        end
        if (fill_we) data[lvic][lidx][k] <= iload;
        if (install) tags[lvic][lidx] <= ltag;
    end
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: behavioural memory responder, fetch scoreboard,
// and a second COUNTW=4 instance sharing the same inputs for counter saturation.
module tb_icache_assoc;
    logic        CLK = 1'b0;
    logic        RST, imemREN, inv, iwait;
    logic [31:0] imemaddr, iload;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr;
    logic [15:0] hit_cnt, miss_cnt;
    logic        s_ihit, s_iREN;
    logic [31:0] s_imemload, s_iaddr;
    logic [3:0]  s_hit_cnt, s_miss_cnt;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] acc_q[$];
    int          wcnt      = 0;
    int          mem_wait  = 1;
    logic [31:0] long_addr = 32'hFFFF_FFFF;
    int          long_wait = 0;
    int          long_cyc  = 0;
    logic        rst_req   = 1'b1;

    icache_assoc #(.WAYS(2), .SETS(8), .BLKWORDS(2), .COUNTW(16)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .inv(inv), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    icache_assoc #(.WAYS(2), .SETS(8), .BLKWORDS(2), .COUNTW(4)) dut_sat (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(s_ihit), .imemload(s_imemload), .inv(inv), .iREN(s_iREN), .iaddr(s_iaddr),
        .iwait(iwait), .iload(iload), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, answer the memory channel, then sample.
    task automatic step(input logic ren, input logic [31:0] addr, input logic inv_i);
        int need;
        @(negedge CLK);
        RST      = rst_req;
        imemREN  = ren;
        imemaddr = addr;
        inv      = inv_i;
        #1;
        if (iREN) begin
            need = (iaddr == long_addr) ? long_wait : mem_wait;
            if (iaddr == long_addr) long_cyc++;
            if (wcnt < need) begin
                iwait = 1'b1;
                iload = 32'hDEAD_BEEF;
                wcnt++;
            end else begin
                iwait = 1'b0;
                iload = memf(iaddr);
                wcnt  = 0;
                acc_q.push_back(iaddr);
            end
        end else begin
            iwait = 1'b0;
            iload = '0;
            wcnt  = 0;
        end
        #1;
        if (!iREN)    chk("iaddr_when_idle", iaddr, 32'h0);
        if (!imemREN) chk("ihit_without_req", {31'b0, ihit}, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] addr, output int lat);
        logic [31:0] e;
        bit          done;
        done = 1'b0;
        lat  = -1;
        exp_q.push_back(memf(addr));
        for (int c = 0; c < 40 && !done; c++) begin
            step(1'b1, addr, 1'b0);
            if (ihit) begin
                e = exp_q.pop_front();
                chk($sformatf("load_%h", addr), imemload, e);
                lat  = c;
                done = 1'b1;
            end
        end
        if (!done) begin
            chk($sformatf("fetch_timeout_%h", addr), {31'b0, ihit}, 32'h1);
            e = exp_q.pop_front();
        end
    endtask

    initial begin
        int lat;
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; inv = 1'b0; iwait = 1'b0; iload = '0;

        // Reset state
        rst_req = 1'b1;
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        rst_req = 1'b0;
        step(1'b0, 32'h0, 1'b0);
        chk("rst_ihit", {31'b0, ihit}, 32'h0);
        chk("rst_iREN", {31'b0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'h0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'h0);

        // Cold miss with memory latency 2, then hit on the other word of the block
        acc_q.delete();
        fetch(32'h100, lat);
        chk("cold_lat", 32'(lat), 32'd6);
        chk("cold_nreq", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() == 2) begin
            chk("cold_iaddr0", acc_q[0], 32'h100);
            chk("cold_iaddr1", acc_q[1], 32'h104);
        end
        fetch(32'h104, lat);
        chk("hit_lat", 32'(lat), 32'd0);
        step(1'b0, 32'h0, 1'b0);
        chk("t1_hit_cnt", 32'(hit_cnt), 32'd2);
        chk("t1_miss_cnt", 32'(miss_cnt), 32'd1);

        // Invalidate in IDLE, then a three-way conflict in set 0
        step(1'b0, 32'h0, 1'b1);
        fetch(32'h100, lat);
        chk("inv_refill_lat", 32'(lat), 32'd6);
        step(1'b0, 32'h0, 1'b1);
        fetch(32'h000, lat); chk("c_fill000", 32'(lat), 32'd6);
        fetch(32'h040, lat); chk("c_fill040", 32'(lat), 32'd6);
        fetch(32'h000, lat); chk("c_hit000", 32'(lat), 32'd0);
        fetch(32'h040, lat); chk("c_hit040", 32'(lat), 32'd0);
        fetch(32'h080, lat); chk("c_fill080", 32'(lat), 32'd6);
        fetch(32'h040, lat); chk("c_keep040", 32'(lat), 32'd0);
        fetch(32'h084, lat); chk("c_hit084", 32'(lat), 32'd0);
        fetch(32'h000, lat); chk("c_evict000", 32'(lat), 32'd6);
        step(1'b0, 32'h0, 1'b0);
        chk("t2_miss_cnt", 32'(miss_cnt), 32'd6);

        // Long stall on word 1: address held, only the post-stall data is kept
        long_addr = 32'h30C; long_wait = 5; long_cyc = 0;
        acc_q.delete();
        fetch(32'h308, lat);
        chk("stall_lat", 32'(lat), 32'd10);
        chk("stall_cycles", 32'(long_cyc), 32'd6);
        chk("stall_nreq", 32'(acc_q.size()), 32'd2);
        long_addr = 32'hFFFF_FFFF;
        fetch(32'h30C, lat);
        chk("stall_word_hit", 32'(lat), 32'd0);

        // Invalidate during word 0 of a fill aborts it
        step(1'b1, 32'h200, 1'b0);
        chk("inv_detect_iREN", {31'b0, iREN}, 32'h0);
        step(1'b1, 32'h200, 1'b1);
        chk("inv_fill_iREN", {31'b0, iREN}, 32'h1);
        chk("inv_fill_iaddr", iaddr, 32'h200);
        step(1'b0, 32'h0, 1'b0);
        chk("inv_abort_iREN", {31'b0, iREN}, 32'h0);
        chk("inv_abort_miss", 32'(miss_cnt), 32'd8);
        fetch(32'h200, lat);
        chk("inv_refetch_lat", 32'(lat), 32'd6);
        step(1'b0, 32'h0, 1'b0);
        chk("inv_refetch_miss", 32'(miss_cnt), 32'd9);

        // Reset in the middle of a fill
        fetch(32'h100, lat);
        fetch(32'h104, lat);
        chk("pre_rst_hit", 32'(lat), 32'd0);
        step(1'b1, 32'h500, 1'b0);
        rst_req = 1'b1;
        step(1'b1, 32'h500, 1'b0);
        chk("rst_fill_iREN", {31'b0, iREN}, 32'h1);
        rst_req = 1'b0;
        step(1'b0, 32'h0, 1'b0);
        chk("mid_rst_iREN", {31'b0, iREN}, 32'h0);
        chk("mid_rst_hit_cnt", 32'(hit_cnt), 32'h0);
        chk("mid_rst_miss_cnt", 32'(miss_cnt), 32'h0);
        fetch(32'h100, lat);
        chk("mid_rst_refill", 32'(lat), 32'd6);

        // Saturation on the 4-bit counter instance
        for (int i = 0; i < 14; i++) begin
            fetch(32'h100, lat);
            chk("sat_hit_lat", 32'(lat), 32'd0);
        end
        step(1'b0, 32'h0, 1'b0);
        chk("sat_15", 32'(s_hit_cnt), 32'd15);
        chk("wide_15", 32'(hit_cnt), 32'd15);
        for (int i = 0; i < 5; i++) fetch(32'h100, lat);
        step(1'b0, 32'h0, 1'b0);
        chk("sat_hold", 32'(s_hit_cnt), 32'd15);
        chk("wide_20", 32'(hit_cnt), 32'd20);
        chk("sat_miss", 32'(s_miss_cnt), 32'd1);

        // Invalidate during an IDLE hit still reports the hit
        step(1'b1, 32'h100, 1'b1);
        chk("inv_hit_ihit", {31'b0, ihit}, 32'h1);
        chk("inv_hit_load", imemload, memf(32'h100));
        fetch(32'h100, lat);
        chk("inv_hit_then_miss", 32'(lat), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
